// File: rtl/stp_rx_controller.sv
`timescale 1ns/1ps
// Serial receive controller: start/data/stop timing, shift strobes and sticky status flags. Optional RX_PARITY_EN adds an even-parity bit check.
// Latency: data_ready rises the cycle after the stop-bit sample (cycle 96 of a default 8N1 frame at CLKS_PER_BIT=10).
// Backpressure: no stall. A frame that completes while data_ready is still set raises overrun_error and the frame is not held.
module stp_rx_controller #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic data_read,
    output logic shift_strobe,
    output logic rx_busy,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic parity_error
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        HOLD
    } state_t;

    state_t          state, next_state;
    logic [TW-1:0]   timer, timer_nxt;
    logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
    logic            serial_prev;
    logic            start_det, frame_done, stop_bad;
`ifdef RX_PARITY_EN
    logic            par_sample, par_acc;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            timer       <= '0;
            bit_cnt     <= '0;
            serial_prev <= 1'b0;  // a high line must be seen before any start is accepted
        end else begin
            state       <= next_state;
            timer       <= timer_nxt;
            bit_cnt     <= bit_cnt_nxt;
            serial_prev <= serial_in;
        end
    end

    always_comb begin
        next_state   = state;
        timer_nxt    = timer;
        bit_cnt_nxt  = bit_cnt;
        shift_strobe = 1'b0;
        start_det    = 1'b0;
        frame_done   = 1'b0;
        stop_bad     = 1'b0;
`ifdef RX_PARITY_EN
        par_sample   = 1'b0;
`endif
        case (state)
            IDLE: begin
                timer_nxt   = '0;
                bit_cnt_nxt = '0;
                if (serial_prev && !serial_in) begin
                    start_det  = 1'b1;
                    next_state = START;
                    timer_nxt  = TW'(1);  // timer tracks cycles since the falling edge
                end
            end
            START: begin
                if (timer == HALF) begin
                    timer_nxt  = serial_in ? '0 : TW'(1);
                    next_state = serial_in ? IDLE : DATA;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == FULL) begin
                    shift_strobe = 1'b1;
                    bit_cnt_nxt  = bit_cnt + 1'b1;
                    timer_nxt    = TW'(1);
                    if (bit_cnt == LAST) begin
`ifdef RX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (timer == FULL) begin
                    par_sample = 1'b1;
                    timer_nxt  = TW'(1);
                    next_state = STOP;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
`endif
            STOP: begin
                if (timer == FULL) begin
                    timer_nxt  = '0;
                    frame_done = serial_in;
                    stop_bad   = !serial_in;
                    next_state = serial_in ? IDLE : HOLD;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            HOLD: begin
                timer_nxt = '0;
                if (serial_in) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                timer_nxt  = '0;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            par_acc      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (start_det) begin
                par_acc      <= 1'b0;
                parity_error <= 1'b0;
            end else if (shift_strobe) begin
                par_acc <= par_acc ^ serial_in;
            end else if (par_sample) begin
                parity_error <= par_acc ^ serial_in;
            end
        end
    end
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (start_det) framing_error <= 1'b0;
            if (stop_bad)  framing_error <= 1'b1;
            // a frame that failed parity is dropped silently apart from its flag
            if (frame_done && !parity_error) begin
                data_ready    <= 1'b1;
                overrun_error <= data_read ? 1'b0 : (overrun_error | data_ready);
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stp_rx_controller.sv
`timescale 1ns/1ps
// Directed bench for stp_rx_controller: frames are pushed to a scoreboard as they are driven,
// and a negedge monitor checks strobe timing, captured data and data_ready timing.
module tb_stp_rx_controller;
    localparam int NB  = 8;
    localparam int CPB = 10;
`ifdef RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int STOP_OFF = CPB * (NB + 1 + PAR) + CPB / 2;

    logic clk = 1'b0;
    logic n_rst, serial_in, data_read;
    logic shift_strobe, rx_busy, data_ready, framing_error, overrun_error, parity_error;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } rdy_t;

    int         cyc = 0;
    int         t0 = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_strobe[$];
    rdy_t       exp_rdy[$];
    logic [7:0] sr = '0;
    logic       dr_prev = 1'b0;

    stp_rx_controller #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .data_read(data_read),
        .shift_strobe(shift_strobe), .rx_busy(rx_busy), .data_ready(data_ready),
        .framing_error(framing_error), .overrun_error(overrun_error), .parity_error(parity_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {shift_strobe, rx_busy, data_ready, framing_error, overrun_error, parity_error};
    endfunction

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Drives one frame LSB first and registers what the DUT should produce for it.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                              input int nstrobe, input bit want_rdy);
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < nstrobe; i++) exp_strobe.push_back(t0 + CPB + CPB / 2 + CPB * i);
        if (want_rdy) exp_rdy.push_back('{t0 + STOP_OFF + 1, d});
        drive_bit(1'b0);
        for (int i = 0; i < NB; i++) drive_bit(d[i]);
        if (PAR != 0) drive_bit((^d) ^ par_flip);
        drive_bit(stop);
    endtask

    task automatic read_ack();
        data_read = 1'b1;
        @(posedge clk);
        #1;
        data_read = 1'b0;
        chk("read_clears_ready", data_ready, 0);
        chk("read_clears_overrun", overrun_error, 0);
    endtask

    always @(negedge clk) begin
        int   e;
        rdy_t r;
        if (n_rst) begin
            if (shift_strobe) begin
                e = (exp_strobe.size() != 0) ? exp_strobe.pop_front() : -1;
                chk("strobe_cycle", cyc, e);
                sr = {serial_in, sr[7:1]};
            end
            if (data_ready && !dr_prev) begin
                r = (exp_rdy.size() != 0) ? exp_rdy.pop_front() : '{-1, 8'h00};
                chk("ready_cycle", cyc, r.cyc);
                chk("ready_data", sr, r.d);
            end
            dr_prev = data_ready;
        end else begin
            dr_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; serial_in = 1'b1; data_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        @(posedge clk); #1 n_rst = 1'b1;
        repeat (3) @(posedge clk);

        // clean frame
        send_frame(8'hA5, 1'b1, 1'b0, NB, 1);
        chk("clean_ready", data_ready, 1);
        chk("clean_flags", {framing_error, overrun_error, parity_error, rx_busy}, 0);
        read_ack();

        // glitch shorter than half a bit
        @(posedge clk); #1;
        t0 = cyc;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("glitch_busy_c5", rx_busy, 1);
        @(negedge clk);
        chk("glitch_idle_c6", rx_busy, 0);
        chk("glitch_flags", {data_ready, framing_error, overrun_error}, 0);
        repeat (5) @(posedge clk);

        // stop bit low, line held low
        send_frame(8'h3C, 1'b0, 1'b0, NB, 0);
        chk("frame_err_set", framing_error, 1);
        chk("frame_err_no_ready", data_ready, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("hold_busy", rx_busy, 1);
        serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_released", rx_busy, 0);
        chk("frame_err_sticky", framing_error, 1);
        repeat (3) @(posedge clk);

        // back-to-back without a read
        send_frame(8'h5A, 1'b1, 1'b0, NB, 1);
        chk("ovr_first_clear", overrun_error, 0);
        send_frame(8'hC3, 1'b1, 1'b0, NB, 0);
        chk("ovr_set", overrun_error, 1);
        chk("ovr_ready_held", data_ready, 1);
        chk("ovr_frame_err_cleared", framing_error, 0);
        read_ack();

        // completion coinciding with data_read
        send_frame(8'h11, 1'b1, 1'b0, NB, 1);
        fork
            send_frame(8'h22, 1'b1, 1'b0, NB, 0);
            begin
                @(posedge clk); #2;
                while (cyc != t0 + STOP_OFF) begin
                    @(posedge clk); #1;
                end
                data_read = 1'b1;
                @(posedge clk); #1;
                data_read = 1'b0;
            end
        join
        chk("sim_read_ready", data_ready, 1);
        chk("sim_read_no_ovr", overrun_error, 0);
        chk("sim_read_data", sr, 8'h22);
        read_ack();

        // reset after the fourth strobe
        fork
            send_frame(8'h96, 1'b1, 1'b0, 4, 0);
            begin
                @(posedge clk); #2;
                while (cyc != t0 + 4 * CPB + CPB / 2 + 2) begin
                    @(posedge clk); #1;
                end
                n_rst = 1'b0;
                #1 chk("midframe_reset_outs", outs(), 0);
            end
        join
        @(posedge clk); #1 n_rst = 1'b1;
        @(negedge clk);
        chk("post_reset_outs", outs(), 0);
        repeat (3) @(posedge clk);
        send_frame(8'h4B, 1'b1, 1'b0, NB, 1);
        chk("after_reset_ready", data_ready, 1);
        chk("after_reset_flags", {framing_error, overrun_error, parity_error}, 0);
        read_ack();

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, NB, 0);
        chk("parity_bad_flag", parity_error, 1);
        chk("parity_bad_no_ready", data_ready, 0);
        send_frame(8'h07, 1'b1, 1'b0, NB, 1);
        chk("parity_ok_flag", parity_error, 0);
        chk("parity_ok_ready", data_ready, 1);
        read_ack();
`endif

        repeat (5) @(posedge clk);
        chk("strobe_queue_drained", exp_strobe.size(), 0);
        chk("ready_queue_drained", exp_rdy.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
